// File: rtl/sigmoid_arbiter.sv
// sigmoid_arbiter
//   Shares one piecewise-linear sigmoid among N requesters. A round-robin
//   arbiter feeds an input register (s1). The sigmoid sits combinationally
//   between s1 and the output register. Results leave on one valid/ready
//   channel, tagged with the requester id. Throughput is one result per cycle.
//
//   Sigmoid approximation (x = signed Q4.(W-4), y = unsigned Q0.W):
//     |x| >= 5          : y = 1 (saturates to all ones)
//     2.375 <= |x| < 5  : y = 0.03125|x| + 0.84375
//     1 <= |x| < 2.375  : y = 0.125|x|   + 0.625
//     |x| < 1           : y = 0.25|x|    + 0.5
//     x < 0             : y = 1 - y(|x|)
//
// Ports
//   clk, rst_n    clock, synchronous active-low reset
//   en            grant enable; when low the pipeline only drains
//   req_valid     [N]   per-requester request valid
//   req_sum       [N*W] per-requester sum, requester i at [i*W +: W]
//   req_ready     [N]   one-hot accept (all zero when nothing is granted)
//   rsp_valid     result valid
//   rsp_ready     downstream accept
//   rsp_data      [W]   sigmoid result
//   rsp_id        [IDW] id of the requester that owns rsp_data
//   idle          both pipeline stages empty
module sigmoid_arbiter #(
    parameter int N   = 4,
    parameter int W   = 16,
    parameter int IDW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_sum,
    output logic [N-1:0]   req_ready,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [W-1:0]   rsp_data,
    output logic [IDW-1:0] rsp_id,
    output logic           idle
);

    localparam int F = W - 4;

    // Breakpoints in Q4.F and segment offsets in Q0.W
    localparam logic [W-1:0] X_SAT  = W'(5 * (2 ** F));
    localparam logic [W-1:0] X_MID  = W'(19 * (2 ** (F - 3)));
    localparam logic [W-1:0] X_ONE  = W'(2 ** F);
    localparam logic [W-1:0] Y_HALF = W'(2 ** (W - 1));
    localparam logic [W-1:0] Y_LOW  = W'(5 * (2 ** (W - 3)));
    localparam logic [W-1:0] Y_HIGH = W'(27 * (2 ** (W - 5)));

    logic           s1_valid_q, s1_valid_d;
    logic [W-1:0]   s1_sum_q,   s1_sum_d;
    logic [IDW-1:0] s1_id_q,    s1_id_d;
    logic [IDW-1:0] rr_ptr_q,   rr_ptr_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [W-1:0]   rsp_data_q,  rsp_data_d;
    logic [IDW-1:0] rsp_id_q,    rsp_id_d;

    logic           out_free, s1_adv, s1_free;
    logic           found;
    logic [IDW-1:0] grant_idx;
    logic [IDW:0]   scan_idx;
    logic [N-1:0]   grant_vec;
    logic [W-1:0]   sel_sum;

    logic           neg;
    logic [W-1:0]   mag;
    logic [W-1:0]   pos_y;
    logic [W-1:0]   sig_y;

    assign out_free = !rsp_valid_q | rsp_ready;
    assign s1_adv   = s1_valid_q & out_free;
    assign s1_free  = !s1_valid_q | s1_adv;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        grant_vec = '0;
        if (rst_n && en && s1_free) begin
            for (int unsigned k = 1; k <= N; k++) begin
                scan_idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
                if (scan_idx >= (IDW+1)'(N))
                    scan_idx = scan_idx - (IDW+1)'(N);
                if (!found && req_valid[scan_idx[IDW-1:0]]) begin
                    found     = 1'b1;
                    grant_idx = scan_idx[IDW-1:0];
                end
            end
        end
        if (found)
            grant_vec[grant_idx] = 1'b1;
    end

    assign req_ready = grant_vec;

    always_comb begin
        sel_sum = '0;
        for (int unsigned i = 0; i < N; i++)
            if (grant_vec[i])
                sel_sum = req_sum[i*W +: W];
    end

    // Piecewise-linear sigmoid on the s1 register
    always_comb begin
        neg   = s1_sum_q[W-1];
        mag   = neg ? (~s1_sum_q + 1'b1) : s1_sum_q;
        pos_y = '0;
        sig_y = '0;
        if (mag >= X_SAT) begin
            sig_y = neg ? '0 : '1;
        end else begin
            if (mag >= X_MID)
                pos_y = (mag >> 1) + Y_HIGH;
            else if (mag >= X_ONE)
                pos_y = (mag << 1) + Y_LOW;
            else
                pos_y = (mag << 2) + Y_HALF;
            // pos_y is strictly between 0.5 and 1, so the W-bit negate is 1 - y
            sig_y = neg ? (~pos_y + 1'b1) : pos_y;
        end
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_sum_d    = s1_sum_q;
        s1_id_d     = s1_id_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;

        if (found) begin
            s1_valid_d = 1'b1;
            s1_sum_d   = sel_sum;
            s1_id_d    = grant_idx;
            rr_ptr_d   = grant_idx;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sig_y;
            rsp_id_d    = s1_id_q;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum_q    <= '0;
            s1_id_q     <= '0;
            rr_ptr_q    <= IDW'(N - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum_q    <= s1_sum_d;
            s1_id_q     <= s1_id_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign idle      = !s1_valid_q & !rsp_valid_q;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// Directed bench for sigmoid_arbiter (N=4, W=16). Expected values are hand
// computed from the piecewise-linear sigmoid and the round-robin order.
module tb_sigmoid_arbiter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [3:0]  req_valid;
    logic [63:0] req_sum;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_id;
    logic        idle;

    int n_vec;
    int n_err;

    sigmoid_arbiter #(.N(4), .W(16), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_sum   (req_sum),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .idle      (idle)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_sum(input int i, input logic [15:0] v);
        req_sum[i*16 +: 16] = v;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic [15:0] d, input logic [1:0] id);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".data"},  32'(rsp_data),  32'(d));
        chk({tag, ".id"},    32'(rsp_id),    32'(id));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".idle"},  32'(idle),      32'd1);
    endtask

    task automatic chk_rdy(input string tag, input logic [3:0] r);
        #1;
        chk(tag, 32'(req_ready), 32'(r));
    endtask

    logic [15:0] ramp_exp [4];
    int g;
    int last;

    initial begin
        n_vec = 0;
        n_err = 0;
        clk = 1'b0;
        rst_n = 1'b0;
        en = 1'b1;
        req_valid = 4'hF;
        req_sum = '0;
        rsp_ready = 1'b0;
        ramp_exp[0] = 16'h8000;
        ramp_exp[1] = 16'hC000;
        ramp_exp[2] = 16'hE000;
        ramp_exp[3] = 16'hF000;

        // Reset state
        chk_rdy("rst_ready", 4'b0000);
        cyc();
        cyc();
        chk_idle("rst");
        chk("rst.data", 32'(rsp_data), 32'h0);
        chk("rst.id",   32'(rsp_id),   32'h0);

        // Single request, sigmoid(0) = 0.5
        rst_n = 1'b1;
        req_valid = 4'b0001;
        set_sum(0, 16'h0000);
        chk_rdy("single.rdy", 4'b0001);
        cyc();
        chk("single.busy", 32'(idle), 32'd0);
        chk("single.nolat", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0000;
        cyc();
        chk_rsp("single", 16'h8000, 2'd0);
        rsp_ready = 1'b1;
        cyc();
        chk_idle("single.done");

        // Saturation, responses in accept order
        set_sum(1, 16'h6000);
        set_sum(2, 16'hA000);
        req_valid = 4'b0110;
        chk_rdy("sat.rdy1", 4'b0010);
        cyc();
        req_valid = 4'b0100;
        chk_rdy("sat.rdy2", 4'b0100);
        cyc();
        chk_rsp("sat.pos", 16'hFFFF, 2'd1);
        req_valid = 4'b0000;
        cyc();
        chk_rsp("sat.neg", 16'h0000, 2'd2);
        cyc();
        chk_idle("sat.done");

        // Fairness: all valid, last grant was 2 so sequence starts at 3
        set_sum(0, 16'h0000);
        set_sum(1, 16'h1000);
        set_sum(2, 16'h2000);
        set_sum(3, 16'h3000);
        req_valid = 4'hF;
        g = 3;
        last = 0;
        for (int c = 0; c < 12; c++) begin
            chk_rdy("rr.rdy", 4'b0001 << g);
            cyc();
            if (c > 0) begin
                chk_rsp("rr.rsp", ramp_exp[last], 2'(last));
                chk("rr.busy", 32'(idle), 32'd0);
            end
            last = g;
            g = (g + 1) % 4;
        end
        req_valid = 4'b0000;
        cyc();
        chk_rsp("rr.tail", ramp_exp[last], 2'(last));
        cyc();
        chk_idle("rr.done");

        // Backpressure with both stages full
        rsp_ready = 1'b0;
        set_sum(3, 16'h0800);
        set_sum(0, 16'hF000);
        set_sum(2, 16'h3000);
        req_valid = 4'b1001;
        chk_rdy("bp.rdy1", 4'b1000);
        cyc();
        req_valid = 4'b0001;
        chk_rdy("bp.rdy2", 4'b0001);
        cyc();
        chk_rsp("bp.first", 16'hA000, 2'd3);
        req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) begin
            chk_rdy("bp.stall_rdy", 4'b0000);
            chk_rsp("bp.hold", 16'hA000, 2'd3);
            cyc();
        end
        rsp_ready = 1'b1;
        chk_rdy("bp.release_rdy", 4'b0100);
        cyc();
        chk_rsp("bp.second", 16'h4000, 2'd0);
        req_valid = 4'b0000;
        cyc();
        chk_rsp("bp.third", 16'hF000, 2'd2);
        cyc();
        chk_idle("bp.done");

        // en low: drain only, then resume after rr_ptr
        set_sum(0, 16'h0000);
        req_valid = 4'b0001;
        chk_rdy("en.rdy0", 4'b0001);
        cyc();
        en = 1'b0;
        set_sum(0, 16'hA000);
        set_sum(1, 16'h6000);
        req_valid = 4'b0011;
        chk_rdy("en.off_rdy1", 4'b0000);
        cyc();
        chk_rsp("en.drain", 16'h8000, 2'd0);
        chk_rdy("en.off_rdy2", 4'b0000);
        cyc();
        chk_idle("en.drained");
        chk_rdy("en.off_rdy3", 4'b0000);
        en = 1'b1;
        chk_rdy("en.resume_rdy", 4'b0010);
        cyc();
        req_valid = 4'b0001;
        chk_rdy("en.next_rdy", 4'b0001);
        cyc();
        chk_rsp("en.rsp1", 16'hFFFF, 2'd1);
        req_valid = 4'b0000;
        cyc();
        chk_rsp("en.rsp0", 16'h0000, 2'd0);
        cyc();
        chk_idle("en.done");

        // Reset mid-operation with both stages full
        rsp_ready = 1'b0;
        set_sum(1, 16'h1000);
        set_sum(2, 16'h2000);
        req_valid = 4'b0110;
        chk_rdy("mrst.rdy1", 4'b0010);
        cyc();
        req_valid = 4'b0100;
        chk_rdy("mrst.rdy2", 4'b0100);
        cyc();
        chk_rsp("mrst.full", 16'hC000, 2'd1);
        rst_n = 1'b0;
        req_valid = 4'b1110;
        chk_rdy("mrst.rst_rdy", 4'b0000);
        cyc();
        chk_idle("mrst.cleared");
        chk("mrst.data", 32'(rsp_data), 32'h0);
        chk("mrst.id",   32'(rsp_id),   32'h0);
        rst_n = 1'b1;
        set_sum(0, 16'h0800);
        req_valid = 4'b1111;
        chk_rdy("mrst.prio0", 4'b0001);
        cyc();
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        cyc();
        chk_rsp("mrst.rsp", 16'hA000, 2'd0);
        cyc();
        chk_idle("mrst.done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sigmoid_arbiter.md
Name: sigmoid_arbiter

Overview:
- Shares one piecewise-linear sigmoid unit among N requesters, e.g. the hidden/visible neuron accumulators in the RBM update path.
- Arbitration is round-robin with per-requester valid/ready input channels.
- The block has a 2-stage pipeline: an input register, then the sigmoid, then an output register.
- Results return on a single valid/ready response channel tagged with the requester id. Throughput is one activation per cycle.

Parameters:
- N, 4, number of requesters (2..16).
- W, 16, data width. Sum is signed Q4.(W-4); result is unsigned Q0.W.
- IDW, 2, requester id width; must equal clog2(N).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  grant enable; when low, no new requests are accepted and the pipeline drains.
- req_valid  in  N  per-requester request valid.
- req_sum  in  N*W  per-requester sum; requester i occupies bits [i*W +: W].
- req_ready  out  N  per-requester accept; at most one bit high.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accept.
- rsp_data  out  W  sigmoid result.
- rsp_id  out  IDW  id of the requester that owns rsp_data.
- idle  out  1  high when both pipeline stages are empty.

Behaviour:
- Reset (rst_n low at a clk edge):
  - s1_valid=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - rr_ptr=N-1, so requester 0 has top priority after reset.
  - idle=1.
  - req_ready is forced to 0 combinationally while rst_n is low.
  - In-flight data is discarded on reset mid-operation; no response is produced for it.
- Advance conditions:
  - out_free = !rsp_valid | rsp_ready.
  - s1_adv = s1_valid & out_free.
  - s1_free = !s1_valid | s1_adv.
- Grant (combinational):
  - If en & s1_free, grant the first i with req_valid[i] set, scanning rr_ptr+1, rr_ptr+2, ... modulo N.
  - req_ready = one-hot of that grant; otherwise all zeros.
  - req_ready may depend on req_valid; no requester may make req_valid depend on req_ready.
- Accept (clk edge where req_valid[g] & req_ready[g]):
  - s1_sum <= req_sum[g], s1_id <= g, s1_valid <= 1, rr_ptr <= g.
  - rr_ptr changes only on an accept.
  - If there is no accept and s1_adv, then s1_valid <= 0.
- Output stage:
  - On s1_adv: rsp_data <= sigmoid(s1_sum), rsp_id <= s1_id, rsp_valid <= 1.
  - On a rsp_ready edge with no s1_adv: rsp_valid <= 0.
  - While rsp_valid & !rsp_ready, rsp_data and rsp_id are held stable.
  - The sigmoid instance is combinational between s1 and the output register.
- Latency: accept at edge k gives rsp_valid high after edge k+1, provided no backpressure.
- Stall behaviour: with both stages full and rsp_ready low, req_ready is all zeros and no state changes.
- Back-to-back operation: with rsp_ready held high, one accept per cycle is sustained. Accept, s1_adv and the output update all occur on the same edge.
- Requester protocol: a requester holds req_valid and req_sum until accepted. Dropping req_valid before accept is allowed; that request is simply not serviced.
- en low: no grants; already-accepted items complete normally. idle = !s1_valid & !rsp_valid.
- Fairness: with all N requesters continuously valid and no stalls, grants cycle 0,1,..,N-1,0. No requester waits more than N-1 grants.
- Response order equals accept order.

Test Plan:
- Reset, then requester 0 only, sum 0x0000 (0.0) → one cycle later rsp_valid=1, rsp_data=0x8000, rsp_id=0; idle returns to 1 after rsp_ready.
- Saturation: req 1 sends 0x6000 (+6.0) and req 2 sends 0xA000 (-6.0) → responses 0xFFFF id1, then 0x0000 id2, in accept order.
- All 4 requesters valid for 12 cycles with rsp_ready=1 → grant sequence 0,1,2,3,0,1,2,3,... with req_ready one-hot every cycle and no idle cycles.
- rsp_ready low for 5 cycles with 2 items in flight → rsp_data/rsp_id stable, req_ready=0; after release the queued item emerges the next cycle and nothing is lost or duplicated.
- en low while requests are pending → no req_ready; in-flight item still completes, idle=1; raising en resumes granting from rr_ptr+1.
- rst_n low for 1 cycle with both stages full → rsp_valid=0, idle=1, and the next grant goes to requester 0 even if others are valid.
